cordic_rr_arbiter: RTL

Round-robin arbiter that shares one iterative CORDIC engine among `N_REQ` neuron lanes of the inference datapath. It grants one requester at a time, captures its operands and mode, issues a single-cycle start to the engine, waits for the engine's done, and returns the result to the granted lane. It sits between the per-lane compute controllers and the shared CORDIC core, below the layer sequencer.

---
 rtl/cordic_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 32 +++
 rtl/cordic_rr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared definitions for the CORDIC round-robin arbiter: operation modes and FSM states.
package cordic_arb_pkg;

  localparam logic [1:0] MODE_LIN  = 2'b00;
  localparam logic [1:0] MODE_HYP  = 2'b01;
  localparam logic [1:0] MODE_CIRC = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above rr_ptr, with wrap.
module rr_pick
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the search loop so no path leaves it unassigned (no latch).
    k    = 0;
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(rr_ptr) + i) % N_REQ;
      if (!any && req[k]) begin
        any     = 1'b1;
        idx     = IDX_W'(k);
        pick[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC engine among N_REQ lanes.
// Optional watchdog in WAIT is enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_rr_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       req_mode,
  input  logic [DATA_W*N_REQ-1:0]  req_a,
  input  logic [DATA_W*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     arb_busy,
  output logic                     eng_start,
  output logic [1:0]               eng_mode,
  output logic [DATA_W-1:0]        eng_a,
  output logic [DATA_W-1:0]        eng_b,
  input  logic                     eng_done,
  input  logic [DATA_W-1:0]        eng_result
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t        state, next_state;
  logic [IDX_W-1:0]  rr_ptr, lane, pick_idx;
  logic [N_REQ-1:0]  pick;
  logic              pick_any;
  logic [1:0]        pick_mode;
  logic [DATA_W-1:0] pick_a, pick_b;
  logic              to_resp, resp_err_n, wd_expired;
  logic [DATA_W-1:0] resp_data_n;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign pick_mode = req_mode[2*pick_idx +: 2];
  assign pick_a    = req_a[DATA_W*pick_idx +: DATA_W];
  assign pick_b    = req_b[DATA_W*pick_idx +: DATA_W];
  assign arb_busy  = (state != ST_IDLE);

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd_cnt <= '0;
    else if (state != ST_WAIT) wd_cnt <= '0;
    else                       wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_expired = (state == ST_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    to_resp     = 1'b0;
    resp_err_n  = 1'b0;
    resp_data_n = '0;
    case (state)
      ST_IDLE:  if (pick_any) next_state = ST_ISSUE;
      ST_ISSUE: begin
        if (eng_mode == MODE_RSVD) begin
          next_state = ST_RESP;
          to_resp    = 1'b1;
          resp_err_n = 1'b1;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done arriving in the same cycle as the watchdog expiry takes priority.
        if (eng_done) begin
          next_state  = ST_RESP;
          to_resp     = 1'b1;
          resp_data_n = eng_result;
        end else if (wd_expired) begin
          next_state = ST_RESP;
          to_resp    = 1'b1;
          resp_err_n = 1'b1;
        end
      end
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_mode  <= '0;
      eng_a     <= '0;
      eng_b     <= '0;
      lane      <= '0;
      rr_ptr    <= '0;
    end else begin
      gnt       <= '0;
      eng_start <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      if (state == ST_IDLE && pick_any) begin
        gnt       <= pick;
        lane      <= pick_idx;
        eng_mode  <= pick_mode;
        eng_a     <= pick_a;
        eng_b     <= pick_b;
        eng_start <= (pick_mode != MODE_RSVD);
      end
      if (to_resp) begin
        rsp_valid <= N_REQ'(1) << lane;
        rsp_data  <= resp_data_n;
        rsp_err   <= resp_err_n;
      end
      if (state == ST_RESP)
        rr_ptr <= (lane == IDX_W'(N_REQ - 1)) ? '0 : lane + 1'b1;
    end
  end

endmodule
